// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: read-mode encodings and
// the default almost-full threshold.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Two words of headroom below full.
    function automatic int default_afull_thresh(input int addr_width);
        return (2 ** addr_width) - 2;
    endfunction

endpackage

// File: rtl/fifo_fwft_reg_file.sv
// Register file used as FIFO storage: one synchronous write port and one
// combinational read port. Contents are never reset.
module reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_w_en,
    input  logic [ADDR_WIDTH-1:0] i_w_addr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic [ADDR_WIDTH-1:0] i_r_addr,
    output logic [DATA_WIDTH-1:0] o_r_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_w_en) begin
            mem[i_w_addr] <= i_w_data;
        end
    end

    assign o_r_data = mem[i_r_addr];

endmodule

// File: rtl/fifo_fwft.sv
// Synchronous FIFO with selectable registered / first-word fall-through read,
// fill level, programmable almost flags and sticky overflow/underflow flags.
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = FIFO_MODE_REG,
    parameter int AFULL_THRESH  = default_afull_thresh(ADDR_WIDTH),
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rsn_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_rd,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_fwft: almost-full/almost-empty threshold out of range 0..DEPTH");
    end
    if (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_fwft: FWFT must be FIFO_MODE_REG or FIFO_MODE_FWFT");
    end

    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

    logic [PW-1:0]         wr_ptr, rd_ptr, level;
    logic                  empty, full, rd_acc, wr_acc;
    logic                  overflow_q, underflow_q;
    logic [DATA_WIDTH-1:0] mem_r_data;

    // The pointer MSB is a wrap bit, so equal low bits mean either empty or full.
    assign level  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign rd_acc = i_rd & ~empty;
    assign wr_acc = i_wr & (~full | rd_acc);

    always_ff @(posedge i_clk or negedge i_rsn_n) begin
        if (!i_rsn_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // A new error in the same cycle as the clear takes priority.
    always_ff @(posedge i_clk or negedge i_rsn_n) begin
        if (!i_rsn_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_wr && !wr_acc)  overflow_q <= 1'b1;
            else if (i_clr_err)   overflow_q <= 1'b0;
            if (i_rd && empty)    underflow_q <= 1'b1;
            else if (i_clr_err)   underflow_q <= 1'b0;
        end
    end

    reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_file (
        .i_clk    (i_clk),
        .i_w_en   (wr_acc),
        .i_w_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .i_w_data (i_w_data),
        .i_r_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .o_r_data (mem_r_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign o_r_data = empty ? '0 : mem_r_data;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_data_q;
        always_ff @(posedge i_clk or negedge i_rsn_n) begin
            if (!i_rsn_n) begin
                r_data_q <= '0;
            end else if (rd_acc) begin
                r_data_q <= mem_r_data;
            end
        end
        assign o_r_data = r_data_q;
    end

    assign o_empty        = empty;
    assign o_full         = full;
    assign o_level        = level;
    assign o_almost_full  = (level >= AFULL_LVL);
    assign o_almost_empty = (level <= AEMPTY_LVL);
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// Bench for fifo_fwft: a registered-read and an FWFT instance share one
// stimulus stream and are checked against a queue-based model.
module tb_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] w_data = 8'h00;

    logic [7:0] r_data_r, r_data_f;
    logic       empty_r, full_r, ae_r, af_r, ovf_r, udf_r;
    logic       empty_f, full_f, ae_f, af_f, ovf_f, udf_f;
    logic [4:0] level_r, level_f;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_ovf = 1'b0, m_udf = 1'b0;

    always #5 clk = ~clk;

    fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_reg (
        .i_clk(clk), .i_rsn_n(rst_n), .i_wr(wr), .i_w_data(w_data), .i_rd(rd),
        .i_clr_err(clr_err), .o_r_data(r_data_r), .o_empty(empty_r), .o_full(full_r),
        .o_almost_empty(ae_r), .o_almost_full(af_r), .o_level(level_r),
        .o_overflow(ovf_r), .o_underflow(udf_r)
    );

    fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fw (
        .i_clk(clk), .i_rsn_n(rst_n), .i_wr(wr), .i_w_data(w_data), .i_rd(rd),
        .i_clr_err(clr_err), .o_r_data(r_data_f), .o_empty(empty_f), .o_full(full_f),
        .o_almost_empty(ae_f), .o_almost_full(af_f), .o_level(level_f),
        .o_overflow(ovf_f), .o_underflow(udf_f)
    );

    // One clock with the given requests; the model queue tracks accepted ops.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic was_empty, ra, wa;
        was_empty = (q.size() == 0);
        ra = r && !was_empty;
        wa = w && (q.size() < 16 || ra);
        wr = w; w_data = d; rd = r; clr_err = c;
        @(posedge clk);
        if (ra) m_rdata = q.pop_front();
        if (wa) q.push_back(d);
        m_ovf = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_udf);
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        q.delete();
        m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        n_checks++;
        if ({r_data_r, empty_r, full_r, ae_r, af_r, level_r, ovf_r, udf_r} !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_reg: got data=%h e=%b f=%b ae=%b af=%b lvl=%0d ovf=%b udf=%b, want 00 1 0 1 0 0 0 0",
                     r_data_r, empty_r, full_r, ae_r, af_r, level_r, ovf_r, udf_r);
        end
        n_checks++;
        if ({r_data_f, empty_f, full_f, ae_f, af_f, level_f, ovf_f, udf_f} !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fwft: got data=%h e=%b f=%b ae=%b af=%b lvl=%0d ovf=%b udf=%b, want 00 1 0 1 0 0 0 0",
                     r_data_f, empty_f, full_f, ae_f, af_f, level_f, ovf_f, udf_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        int sz;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            sz = q.size();
            n_checks++;
            if ({level_r, full_r, af_r, ae_r, empty_r} !== {5'(sz), sz == 16, sz >= 14, sz <= 2, 1'b0}) begin
                n_fail++;
                $display("FAIL fill_status[%0d]: got lvl=%0d f=%b af=%b ae=%b e=%b, want lvl=%0d f=%b af=%b ae=%b e=0",
                         i, level_r, full_r, af_r, ae_r, empty_r, sz, sz == 16, sz >= 14, sz <= 2);
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (r_data_f !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain_fwft_head[%0d]: got %h want %h", i, r_data_f, 8'(i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (r_data_r !== 8'(i) || level_r !== 5'(15 - i)) begin
                n_fail++;
                $display("FAIL drain_reg[%0d]: got data=%h lvl=%0d want data=%h lvl=%0d",
                         i, r_data_r, level_r, 8'(i), 15 - i);
            end
        end
        n_checks++;
        if ({empty_r, empty_f, r_data_f} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL drained_empty: got e_reg=%b e_fw=%b fw_data=%h want 1 1 00", empty_r, empty_f, r_data_f);
        end
    endtask

    task automatic test_fwft_single();
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        n_checks++;
        if ({r_data_f, empty_f} !== {8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL fwft_visible: got data=%h e=%b want a5 0", r_data_f, empty_f);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (r_data_f !== 8'hA5 || r_data_r !== 8'h00) begin
            n_fail++;
            $display("FAIL fwft_hold: got fw=%h reg=%h want fw=a5 reg=00", r_data_f, r_data_r);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({r_data_f, empty_f, r_data_r} !== {8'h00, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL fwft_pop: got fw=%h e=%b reg=%h want fw=00 e=1 reg=a5", r_data_f, empty_f, r_data_r);
        end
    endtask

    task automatic test_full_rdwr();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++;
        if ({level_r, full_r, r_data_r, ovf_r, r_data_f} !== {5'd16, 1'b1, 8'h20, 1'b0, 8'h21}) begin
            n_fail++;
            $display("FAIL full_rdwr: got lvl=%0d f=%b reg=%h ovf=%b fw=%h want 16 1 20 0 21",
                     level_r, full_r, r_data_r, ovf_r, r_data_f);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (r_data_r !== ((i == 15) ? 8'h55 : 8'(8'h21 + i))) begin
                n_fail++;
                $display("FAIL full_rdwr_drain[%0d]: got %h want %h", i, r_data_r, (i == 15) ? 8'h55 : 8'(8'h21 + i));
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({udf_r, ovf_r, r_data_r, udf_f} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL underflow_set: got udf=%b ovf=%b data=%h udf_fw=%b want 1 0 00 1", udf_r, ovf_r, r_data_r, udf_f);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (udf_r !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clr: got %b want 0", udf_r);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        n_checks++;
        if ({ovf_r, ovf_f, level_r} !== {1'b1, 1'b1, 5'd16}) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b ovf_fw=%b lvl=%0d want 1 1 16", ovf_r, ovf_f, level_r);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (ovf_r !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clr: got %b want 0", ovf_r);
        end
        step(1'b1, 8'h88, 1'b0, 1'b1);
        n_checks++;
        if ({ovf_r, ovf_f} !== 2'b11) begin
            n_fail++;
            $display("FAIL overflow_set_wins: got reg=%b fw=%b want 1 1", ovf_r, ovf_f);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (r_data_r !== 8'(8'h40 + i)) begin
                n_fail++;
                $display("FAIL dropped_words[%0d]: got %h want %h", i, r_data_r, 8'(8'h40 + i));
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        n_checks++;
        if ({level_r, udf_r, r_data_r, r_data_f} !== {5'd1, 1'b1, 8'h4F, 8'h3C}) begin
            n_fail++;
            $display("FAIL empty_rdwr: got lvl=%0d udf=%b reg=%h fw=%h want 1 1 4f 3c", level_r, udf_r, r_data_r, r_data_f);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if ({udf_r, r_data_r, empty_r} !== {1'b0, 8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL pop_and_clear: got udf=%b reg=%h e=%b want 0 3c 1", udf_r, r_data_r, empty_r);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if ({udf_r, udf_f} !== 2'b11) begin
            n_fail++;
            $display("FAIL underflow_set_wins: got reg=%b fw=%b want 1 1", udf_r, udf_f);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d, head;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            step(1'b1, d, 1'b0, 1'b0);
            n_checks++;
            if (level_r !== 5'(q.size()) || level_r > 5'd16 || ovf_r !== m_ovf) begin
                n_fail++;
                $display("FAIL wrap_level[%0d]: got lvl=%0d ovf=%b want lvl=%0d ovf=%b", i, level_r, ovf_r, q.size(), m_ovf);
            end
            head = (q.size() != 0) ? q[0] : 8'h00;
            n_checks++;
            if (r_data_f !== head) begin
                n_fail++;
                $display("FAIL wrap_fwft_head[%0d]: got %h want %h", i, r_data_f, head);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (r_data_r !== m_rdata || udf_r !== m_udf) begin
                n_fail++;
                $display("FAIL wrap_data[%0d]: got %h udf=%b want %h udf=%b", i, r_data_r, udf_r, m_rdata, m_udf);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({level_r, r_data_r} !== {5'd7, 8'h60}) begin
            n_fail++;
            $display("FAIL pre_reset: got lvl=%0d data=%h want 7 60", level_r, r_data_r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({r_data_r, empty_r, full_r, ae_r, af_r, level_r, ovf_r, udf_r} !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_reg: got data=%h e=%b f=%b ae=%b af=%b lvl=%0d ovf=%b udf=%b, want 00 1 0 1 0 0 0 0",
                     r_data_r, empty_r, full_r, ae_r, af_r, level_r, ovf_r, udf_r);
        end
        n_checks++;
        if ({r_data_f, empty_f, level_f} !== {8'h00, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL async_reset_fwft: got data=%h e=%b lvl=%0d want 00 1 0", r_data_f, empty_f, level_f);
        end
        #1;
        rst_n = 1'b1;
        q.delete();
        m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t want below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_fwft_single();
        test_full_rdwr();
        test_errors();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
